// File: rtl/seg_mux_display.sv
// Multiplexed N-digit 7-segment driver: refresh prescaler, tear-free double-buffered
// digit load over valid/ready, per-digit dp/blank/blink masks and leading-zero blanking.
module seg_mux_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 25000,
  parameter int BLINK_FRAMES = 128,
  parameter bit HEX_MODE     = 1'b0,
  parameter bit SEG_ACT_LOW  = 1'b1,
  parameter bit AN_ACT_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [4*NUM_DIGITS-1:0] upd_digits,
  input  logic [NUM_DIGITS-1:0]   upd_dp,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_suppress,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

  localparam logic [6:0]            SEG_DARK = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_DARK  = SEG_ACT_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_IDLE  = AN_ACT_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  typedef enum logic {
    BLINK_ON  = 1'b0,
    BLINK_OFF = 1'b1
  } blink_phase_t;

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] active_digits;
  logic [NUM_DIGITS-1:0]   active_dp;
  logic [4*NUM_DIGITS-1:0] shadow_digits;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    pending;
  logic [BW-1:0]           blink_cnt;
  blink_phase_t            phase;

  logic                    tick;
  logic                    last_idx;
  logic                    boundary;
  logic                    accept;
  logic                    load_active;
  logic [IW-1:0]           next_idx;
  logic [4*NUM_DIGITS-1:0] next_digits;
  logic [NUM_DIGITS-1:0]   next_dp;
  logic [BW-1:0]           next_cnt;
  blink_phase_t            next_phase;

  logic [NUM_DIGITS-1:0]   zero_from;
  logic [3:0]              sel_code;
  logic                    sel_dp;
  logic                    sel_blank;
  logic                    sel_blink;
  logic                    sel_lz;
  logic                    code_valid;
  logic                    dark;
  logic [6:0]              seg_lit;
  logic                    dp_lit;
  logic [NUM_DIGITS-1:0]   an_onehot;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'h0:    glyph = 7'h3F;
      4'h1:    glyph = 7'h06;
      4'h2:    glyph = 7'h5B;
      4'h3:    glyph = 7'h4F;
      4'h4:    glyph = 7'h66;
      4'h5:    glyph = 7'h6D;
      4'h6:    glyph = 7'h7D;
      4'h7:    glyph = 7'h07;
      4'h8:    glyph = 7'h7F;
      4'h9:    glyph = 7'h6F;
      4'hA:    glyph = 7'h77;
      4'hB:    glyph = 7'h7C;
      4'hC:    glyph = 7'h39;
      4'hD:    glyph = 7'h5E;
      4'hE:    glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  assign upd_ready = ~pending;

  // The outputs for the new digit are computed from the values that will be
  // live after this edge, so a freshly copied digit set shows from digit 0 on.
  always_comb begin
    tick        = (presc == PRESC_MAX);
    last_idx    = (idx == IDX_MAX);
    boundary    = tick && last_idx;
    accept      = upd_valid && !pending;
    load_active = boundary && pending;
    next_idx    = last_idx ? '0 : idx + 1'b1;
    next_digits = load_active ? shadow_digits : active_digits;
    next_dp     = load_active ? shadow_dp : active_dp;
    next_cnt    = blink_cnt;
    next_phase  = phase;
    if (boundary) begin
      if (blink_cnt == BLINK_MAX) begin
        next_cnt   = '0;
        next_phase = (phase == BLINK_ON) ? BLINK_OFF : BLINK_ON;
      end else begin
        next_cnt = blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      zero_from[i] = ((next_digits >> (4 * i)) == '0);
    end
  end

  always_comb begin
    sel_code  = 4'd0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    sel_blink = 1'b0;
    sel_lz    = 1'b0;
    an_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_onehot[i] = (next_idx == IW'(i));
      if (next_idx == IW'(i)) begin
        sel_code  = next_digits[4*i +: 4];
        sel_dp    = next_dp[i];
        sel_blank = blank_mask[i];
        sel_blink = blink_mask[i];
        sel_lz    = (i != 0) && zero_from[i];
      end
    end
  end

  // A dark digit keeps its anode driven so every digit sees the same duty cycle.
  always_comb begin
    code_valid = HEX_MODE || (sel_code <= 4'd9);
    dark       = sel_blank
              || (sel_blink && (next_phase == BLINK_OFF))
              || !code_valid
              || (lz_suppress && sel_lz);
    seg_lit    = dark ? 7'h00 : glyph(sel_code);
    dp_lit     = !dark && sel_dp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc       <= '0;
      idx         <= '0;
      seg         <= SEG_DARK;
      dp          <= DP_DARK;
      an          <= AN_IDLE;
      frame_start <= 1'b0;
    end else begin
      presc       <= tick ? '0 : presc + 1'b1;
      frame_start <= boundary;
      if (tick) begin
        idx <= next_idx;
        seg <= seg_lit ^ SEG_DARK;
        dp  <= dp_lit ^ DP_DARK;
        an  <= an_onehot ^ AN_IDLE;
      end
    end
  end

  // Copy and accept are mutually exclusive: copy needs pending, accept needs !pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_digits <= '0;
      active_dp     <= '0;
      shadow_digits <= '0;
      shadow_dp     <= '0;
      pending       <= 1'b0;
    end else if (load_active) begin
      active_digits <= shadow_digits;
      active_dp     <= shadow_dp;
      pending       <= 1'b0;
    end else if (accept) begin
      shadow_digits <= upd_digits;
      shadow_dp     <= upd_dp;
      pending       <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      phase     <= BLINK_ON;
    end else if (boundary) begin
      blink_cnt <= next_cnt;
      phase     <= next_phase;
    end
  end

endmodule

// File: tb/tb_seg_mux_display.sv
// Self-checking bench for seg_mux_display: time-based reference model compared every
// cycle, plus hand-computed frame checks and randomized updates and masks.
module tb_seg_mux_display;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int BF  = 2;

  logic        clk;
  logic        rst;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_digits;
  logic [3:0]  upd_dp;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic        lz_suppress;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit          model_live = 0;
  int          cyc;
  logic [19:0] pend_q[$];
  logic [15:0] m_digits;
  logic [3:0]  m_dp;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_an;
  logic        exp_fs;
  logic        exp_ready;

  int          n;
  bit          dark0[8];

  seg_mux_display #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (DIV),
    .BLINK_FRAMES(BF),
    .HEX_MODE    (1'b0),
    .SEG_ACT_LOW (1'b1),
    .AN_ACT_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_digits (upd_digits),
    .upd_dp     (upd_dp),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .lz_suppress(lz_suppress),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_start(frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] glyph_of(input logic [3:0] code);
    case (code)
      4'd0:    glyph_of = 7'h3F;
      4'd1:    glyph_of = 7'h06;
      4'd2:    glyph_of = 7'h5B;
      4'd3:    glyph_of = 7'h4F;
      4'd4:    glyph_of = 7'h66;
      4'd5:    glyph_of = 7'h6D;
      4'd6:    glyph_of = 7'h7D;
      4'd7:    glyph_of = 7'h07;
      4'd8:    glyph_of = 7'h7F;
      4'd9:    glyph_of = 7'h6F;
      default: glyph_of = 7'h00;
    endcase
  endfunction

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    cyc       = 0;
    pend_q.delete();
    m_digits  = '0;
    m_dp      = '0;
    exp_seg   = 7'h7F;
    exp_dp    = 1'b1;
    exp_an    = 4'hF;
    exp_fs    = 1'b0;
    exp_ready = 1'b1;
  endtask

  // Position in time after reset determines digit and frame; updates queue until a boundary.
  task automatic model_step();
    bit         acc;
    bit         off;
    bit         dk;
    int         t;
    int         k;
    logic [3:0] code;
    acc    = upd_valid && (pend_q.size() == 0);
    exp_fs = 1'b0;
    if ((cyc % DIV) == DIV - 1) begin
      t = (cyc + 1) / DIV;
      k = t % N;
      if (k == 0) begin
        exp_fs = 1'b1;
        if (pend_q.size() > 0) {m_dp, m_digits} = pend_q.pop_front();
      end
      off  = (((t / N) / BF) % 2) == 1;
      code = m_digits[4*k +: 4];
      dk   = blank_mask[k] || (blink_mask[k] && off) || (code > 4'd9)
          || (lz_suppress && (k != 0) && ((m_digits >> (4 * k)) == 16'd0));
      exp_seg = dk ? 7'h7F : ~glyph_of(code);
      exp_dp  = dk ? 1'b1 : ~m_dp[k];
      exp_an  = ~(4'b0001 << k);
    end
    if (acc) pend_q.push_back({upd_dp, upd_digits});
    cyc++;
    exp_ready = (pend_q.size() == 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        model_reset();
        model_live = 1;
      end else if (model_live) begin
        model_step();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        checkOutput("model_seg", 32'(seg), 32'(exp_seg));
        checkOutput("model_dp", 32'(dp), 32'(exp_dp));
        checkOutput("model_an", 32'(an), 32'(exp_an));
        checkOutput("model_frame_start", 32'(frame_start), 32'(exp_fs));
        checkOutput("model_upd_ready", 32'(upd_ready), 32'(exp_ready));
      end
    end
  end

  // Offer a digit set; called just after a falling edge, returns just after the next one.
  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p);
    int w;
    upd_valid  = 1'b1;
    upd_digits = d;
    upd_dp     = p;
    w = 0;
    while (!upd_ready && w < 100) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (w >= 100) checkOutput("offer_ready_timeout", 32'(upd_ready), 32'd1);
    @(negedge clk);
    #1;
    upd_valid  = 1'b0;
    upd_digits = 16'($urandom);
    upd_dp     = 4'($urandom);
  endtask

  task automatic wait_frame();
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!frame_start && w < 64);
    checkOutput("frame_wait", 32'(frame_start), 32'd1);
  endtask

  // Called at the falling edge where frame_start is high; returns at the next frame start.
  task automatic checkFrame(input string nm, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] edp);
    logic [6:0] es[4];
    logic [3:0] ea;
    es[0] = s0;
    es[1] = s1;
    es[2] = s2;
    es[3] = s3;
    for (int k = 0; k < N; k++) begin
      ea = ~(4'b0001 << k);
      checkOutput({nm, "_an"}, 32'(an), 32'(ea));
      checkOutput({nm, "_seg"}, 32'(seg), 32'(es[k]));
      checkOutput({nm, "_dp"}, 32'(dp), 32'(edp[k]));
      repeat (DIV) @(negedge clk);
    end
  endtask

  initial begin
    rst         = 1'b1;
    upd_valid   = 1'b0;
    upd_digits  = '0;
    upd_dp      = '0;
    blank_mask  = '0;
    blink_mask  = '0;
    lz_suppress = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_an", 32'(an), 32'hF);
    checkOutput("rst_seg", 32'(seg), 32'h7F);
    checkOutput("rst_dp", 32'(dp), 32'h1);
    checkOutput("rst_frame_start", 32'(frame_start), 32'h0);
    checkOutput("rst_upd_ready", 32'(upd_ready), 32'h1);
    #1 rst = 1'b0;

    wait_frame();
    checkOutput("first_frame_an", 32'(an), 32'hE);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 64);
    checkOutput("frame_period", 32'(n), 32'd16);

    repeat (6) @(negedge clk);
    #1;
    applyStimulus(16'h1234, 4'b0010);
    checkOutput("old_digits_kept", 32'(seg), 32'h40);
    wait_frame();
    checkFrame("load1234", 7'h19, 7'h30, 7'h24, 7'h79, 4'b1101);

    #1;
    lz_suppress = 1'b1;
    applyStimulus(16'h0007, 4'b0000);
    wait_frame();
    checkFrame("lz0007", 7'h78, 7'h7F, 7'h7F, 7'h7F, 4'hF);
    #1;
    applyStimulus(16'h0000, 4'b0000);
    wait_frame();
    checkFrame("lz0000", 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'hF);

    #1;
    lz_suppress = 1'b0;
    applyStimulus(16'h1111, 4'b0000);
    checkOutput("b2b_ready_low", 32'(upd_ready), 32'h0);
    applyStimulus(16'h2222, 4'b0000);
    checkOutput("b2b_first_an", 32'(an), 32'hE);
    checkOutput("b2b_first_seg", 32'(seg), 32'h79);
    wait_frame();
    checkOutput("b2b_second_seg", 32'(seg), 32'h24);

    #1;
    blink_mask = 4'b0001;
    applyStimulus(16'h0008, 4'b0000);
    for (int f = 0; f < 8; f++) begin
      wait_frame();
      dark0[f] = (seg == 7'h7F);
    end
    for (int f = 0; f < 6; f++) begin
      checkOutput("blink_half_period", 32'(dark0[f] ^ dark0[f+2]), 32'd1);
    end
    #1;
    blink_mask = 4'b0000;

    applyStimulus(16'h000A, 4'b0001);
    wait_frame();
    checkFrame("code_A", 7'h7F, 7'h40, 7'h40, 7'h40, 4'hF);

    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      #1;
      blank_mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      blink_mask  = 4'($urandom);
      lz_suppress = 1'($urandom);
      if ($urandom_range(0, 1) == 1) applyStimulus(16'($urandom), 4'($urandom));
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end

    #1;
    blank_mask  = '0;
    blink_mask  = '0;
    lz_suppress = 1'b0;
    wait_frame();
    #1;
    applyStimulus(16'h9999, 4'hF);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_an", 32'(an), 32'hF);
    checkOutput("midrst_upd_ready", 32'(upd_ready), 32'h1);
    checkOutput("midrst_seg", 32'(seg), 32'h7F);
    checkOutput("midrst_frame_start", 32'(frame_start), 32'h0);
    #1 rst = 1'b0;
    wait_frame();
    checkOutput("post_rst_seg", 32'(seg), 32'h40);
    checkOutput("post_rst_dp", 32'(dp), 32'h1);
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
